// File: rtl/soc_addr_map_pkg.sv
// SoC peripheral address map shared by the crossbar decoder.
// Holds the rule type and the reset base/length tables derived from the peripheral map.
package soc_addr_map_pkg;

    localparam int NB_PERIPHERALS = 11;
    localparam int MAP_AW         = 64;

    typedef struct packed {
        logic [MAP_AW-1:0] base;
        logic [MAP_AW-1:0] len;
    } addr_rule_t;

    typedef logic [NB_PERIPHERALS-1:0][MAP_AW-1:0] addr_vec_t;

    localparam addr_rule_t PERIPH_MAP [NB_PERIPHERALS] = '{
        '{base: 64'h0000_0000_8000_0000, len: 64'h0000_0000_4000_0000}, // 0  DRAM
        '{base: 64'h0000_0000_0000_1000, len: 64'h0000_0000_0000_1000}, // 1  BOOTROM
        '{base: 64'h0000_0000_0800_0000, len: 64'h0000_0000_0010_0000}, // 2  SRAM
        '{base: 64'h0000_0000_0C00_0000, len: 64'h0000_0000_0400_0000}, // 3  PLIC
        '{base: 64'h0000_0000_0200_0000, len: 64'h0000_0000_000C_0000}, // 4  CLINT
        '{base: 64'h0000_0000_1000_0000, len: 64'h0000_0000_0000_1000}, // 5  UART
        '{base: 64'h0000_0000_1000_1000, len: 64'h0000_0000_0000_1000}, // 6  GPIO
        '{base: 64'h0000_0000_1000_2000, len: 64'h0000_0000_0000_1000}, // 7  SPI
        '{base: 64'h0000_0000_1000_3000, len: 64'h0000_0000_0000_1000}, // 8  I2C
        '{base: 64'h0000_0000_1000_4000, len: 64'h0000_0000_0000_1000}, // 9  TIMER
        '{base: 64'h0000_0000_0000_0000, len: 64'h0000_0000_0000_1000}  // 10 DEBUG
    };

    function automatic addr_vec_t map_bases();
        addr_vec_t v;
        for (int i = 0; i < NB_PERIPHERALS; i++) v[i] = PERIPH_MAP[i].base;
        return v;
    endfunction

    function automatic addr_vec_t map_lengths();
        addr_vec_t v;
        for (int i = 0; i < NB_PERIPHERALS; i++) v[i] = PERIPH_MAP[i].len;
        return v;
    endfunction

    localparam addr_vec_t RESET_BASE   = map_bases();
    localparam addr_vec_t RESET_LENGTH = map_lengths();

endpackage

// File: rtl/soc_addr_rule_match.sv
// Single decode-rule comparator. The offset form keeps rules that end at the top
// of the address space from overflowing.
module soc_addr_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] len_i,
    output logic                 hit_o
);

    logic [AddrWidth-1:0] offset;

    assign offset = addr_i - base_i;
    assign hit_o  = (len_i != '0) && (addr_i >= base_i) && (offset < len_i);

endmodule

// File: rtl/soc_addr_decoder.sv
// Runtime-reprogrammable address decoder: rule table, lowest-index priority,
// registered valid/ready output, sticky config lock and saturating hit counters.
module soc_addr_decoder
    import soc_addr_map_pkg::*;
#(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned NumRules   = NB_PERIPHERALS,
    parameter int unsigned IdxWidth   = $clog2(NumRules + 1),
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned DefaultIdx = NumRules,
    parameter logic [NumRules-1:0][AddrWidth-1:0] ResetBase   = RESET_BASE,
    parameter logic [NumRules-1:0][AddrWidth-1:0] ResetLength = RESET_LENGTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [IdxWidth-1:0]  dec_idx_o,
    output logic                 dec_err_o,
    output logic [AddrWidth-1:0] dec_addr_o,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_locked_o,
    input  logic                 cfg_cnt_clr_i,
    output logic [CntWidth-1:0]  cfg_cnt_o
);

    logic [NumRules-1:0][AddrWidth-1:0] base_q, len_q;
    logic [NumRules-1:0][CntWidth-1:0]  cnt_q;
    logic [NumRules-1:0]                hit;
    logic                               lock_q;
    logic                               valid_q, err_q;
    logic [IdxWidth-1:0]                idx_q;
    logic [AddrWidth-1:0]               addr_q;
    logic [IdxWidth-1:0]                idx_d;
    logic                               err_d;
    logic                               accept;
    logic                               cfg_wr_ok;

    for (genvar g = 0; g < NumRules; g++) begin : g_rule
        soc_addr_rule_match #(.AddrWidth(AddrWidth)) u_match (
            .addr_i (req_addr_i),
            .base_i (base_q[g]),
            .len_i  (len_q[g]),
            .hit_o  (hit[g])
        );
    end

    // Walk downward so the lowest matching index is the last assignment and wins.
    always_comb begin
        idx_d = IdxWidth'(DefaultIdx);
        err_d = 1'b1;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx_d = IdxWidth'(i);
                err_d = 1'b0;
            end
        end
    end

    assign req_ready_o = !valid_q || dec_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else if (req_ready_o) begin
            valid_q <= req_valid_i;
            if (req_valid_i) begin
                idx_q  <= idx_d;
                err_q  <= err_d;
                addr_q <= req_addr_i;
            end
        end
    end

    assign cfg_wr_ok = cfg_we_i && !lock_q && (cfg_idx_i < IdxWidth'(NumRules));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            base_q <= ResetBase;
            len_q  <= ResetLength;
        end else begin
            lock_q <= lock_q || cfg_lock_i;
            for (int i = 0; i < NumRules; i++) begin
                if (cfg_wr_ok && (cfg_idx_i == IdxWidth'(i))) begin
                    base_q[i] <= cfg_base_i;
                    len_q[i]  <= cfg_len_i;
                end
            end
        end
    end

    // Every rule that matches an accepted request counts, including shadowed overlaps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NumRules; i++) begin
                if (cfg_cnt_clr_i) begin
                    cnt_q[i] <= '0;
                end else if (accept && hit[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cfg_cnt_o = '0;
        for (int i = 0; i < NumRules; i++) begin
            if (cfg_idx_i == IdxWidth'(i)) cfg_cnt_o = cnt_q[i];
        end
    end

    assign dec_valid_o  = valid_q;
    assign dec_idx_o    = idx_q;
    assign dec_err_o    = err_q;
    assign dec_addr_o   = addr_q;
    assign cfg_locked_o = lock_q;

endmodule

// File: tb/tb_soc_addr_decoder.sv
// Directed bench for soc_addr_decoder: reset map, miss route, backpressure,
// reprogramming/lock, overlap/wrap, counter saturation/clear and async reset.
module tb_soc_addr_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [3:0]  dec_idx_o;
    logic        dec_err_o;
    logic [63:0] dec_addr_o;
    logic        cfg_we_i;
    logic [3:0]  cfg_idx_i;
    logic [63:0] cfg_base_i;
    logic [63:0] cfg_len_i;
    logic        cfg_lock_i;
    logic        cfg_locked_o;
    logic        cfg_cnt_clr_i;
    logic [15:0] cfg_cnt_o;

    int checks = 0;
    int errors = 0;

    soc_addr_decoder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_idx_o     (dec_idx_o),
        .dec_err_o     (dec_err_o),
        .dec_addr_o    (dec_addr_o),
        .cfg_we_i      (cfg_we_i),
        .cfg_idx_i     (cfg_idx_i),
        .cfg_base_i    (cfg_base_i),
        .cfg_len_i     (cfg_len_i),
        .cfg_lock_i    (cfg_lock_i),
        .cfg_locked_o  (cfg_locked_o),
        .cfg_cnt_clr_i (cfg_cnt_clr_i),
        .cfg_cnt_o     (cfg_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [3:0] idx, input logic err,
                           input logic [63:0] addr);
        chk({tag, ".valid"}, 64'(dec_valid_o), 64'd1);
        chk({tag, ".idx"},   64'(dec_idx_o),   64'(idx));
        chk({tag, ".err"},   64'(dec_err_o),   64'(err));
        chk({tag, ".addr"},  dec_addr_o,       addr);
    endtask

    // One request with dec_ready high, check the result, then let the output drain.
    task automatic send(input string tag, input logic [63:0] addr, input logic [3:0] idx,
                        input logic err);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        dec_ready_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_dec(tag, idx, err, addr);
        @(negedge clk_i);
        chk({tag, ".drop"}, 64'(dec_valid_o), 64'd0);
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [63:0] base,
                             input logic [63:0] len);
        @(negedge clk_i);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = idx;
        cfg_base_i = base;
        cfg_len_i  = len;
        @(negedge clk_i);
        cfg_we_i   = 1'b0;
    endtask

    task automatic cnt_of(input string tag, input logic [3:0] idx, input logic [15:0] exp);
        cfg_idx_i = idx;
        #1;
        chk(tag, 64'(cfg_cnt_o), 64'(exp));
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_addr_i    = '0;
        dec_ready_i   = 1'b1;
        cfg_we_i      = 1'b0;
        cfg_idx_i     = '0;
        cfg_base_i    = '0;
        cfg_len_i     = '0;
        cfg_lock_i    = 1'b0;
        cfg_cnt_clr_i = 1'b0;

        repeat (2) @(negedge clk_i);
        chk("rst.valid",  64'(dec_valid_o),  64'd0);
        chk("rst.idx",    64'(dec_idx_o),    64'd0);
        chk("rst.err",    64'(dec_err_o),    64'd0);
        chk("rst.addr",   dec_addr_o,        64'd0);
        chk("rst.locked", 64'(cfg_locked_o), 64'd0);
        chk("rst.ready",  64'(req_ready_o),  64'd1);
        cnt_of("rst.cnt5", 4'd5, 16'd0);
        rst_ni = 1'b1;

        // Reset map, first-cycle latency, miss route
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000_0010;
        #1;
        chk("lat.not_yet", 64'(dec_valid_o), 64'd0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_dec("uart", 4'd5, 1'b0, 64'h1000_0010);
        @(negedge clk_i);
        send("dram", 64'h8000_0000, 4'd0, 1'b0);
        send("miss", 64'h6000_0000, 4'd11, 1'b1);
        cnt_of("miss.cnt5", 4'd5, 16'd1);
        cnt_of("miss.cnt10", 4'd10, 16'd0);
        cnt_of("cnt.oob", 4'd11, 16'd0);
        send("uart_end", 64'h1000_0FFF, 4'd5, 1'b0);
        send("gpio_start", 64'h1000_1000, 4'd6, 1'b0);

        // Backpressure: three stalled cycles, then back-to-back
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000_1000;
        dec_ready_i = 1'b0;
        @(negedge clk_i);
        req_addr_i  = 64'h1000_2000;
        for (int i = 0; i < 3; i++) begin
            chk_dec("bp.hold", 4'd6, 1'b0, 64'h1000_1000);
            chk("bp.ready", 64'(req_ready_o), 64'd0);
            @(negedge clk_i);
        end
        dec_ready_i = 1'b1;
        #1;
        chk("bp.ready_up", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        chk_dec("b2b.spi", 4'd7, 1'b0, 64'h1000_2000);
        req_addr_i = 64'h1000_3000;
        @(negedge clk_i);
        chk_dec("b2b.i2c", 4'd8, 1'b0, 64'h1000_3000);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b.drop", 64'(dec_valid_o), 64'd0);

        // Reprogram, wrap at the top of the address space, overlap priority
        cfg_write(4'd10, 64'h6000_0000, 64'h1000);
        send("rule10", 64'h6000_0004, 4'd10, 1'b0);
        cnt_of("rule10.cnt", 4'd10, 16'd1);
        cfg_write(4'd2, 64'hFFFF_FFFF_FFFF_F000, 64'h1000);
        send("wrap.top", 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 1'b0);
        send("wrap.below", 64'hFFFF_FFFF_FFFF_EFFF, 4'd11, 1'b1);
        cfg_write(4'd1, 64'h0C00_0000, 64'h1000);
        send("ovl.low", 64'h0C00_0010, 4'd1, 1'b0);
        send("ovl.rule3", 64'h0C00_2000, 4'd3, 1'b0);
        cfg_write(4'd11, 64'h6000_0000, 64'h0);
        send("oob_write", 64'h6000_0004, 4'd10, 1'b0);

        // Same-cycle write applies only to the next request
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000_5000;
        cfg_we_i    = 1'b1;
        cfg_idx_i   = 4'd9;
        cfg_base_i  = 64'h1000_5000;
        cfg_len_i   = 64'h100;
        @(negedge clk_i);
        cfg_we_i    = 1'b0;
        req_valid_i = 1'b0;
        chk_dec("samecyc.old", 4'd11, 1'b1, 64'h1000_5000);
        send("samecyc.new", 64'h1000_5000, 4'd9, 1'b0);

        // Lock, then a disabling write is ignored
        @(negedge clk_i);
        cfg_lock_i = 1'b1;
        @(negedge clk_i);
        cfg_lock_i = 1'b0;
        chk("lock.set", 64'(cfg_locked_o), 64'd1);
        cfg_write(4'd10, 64'h6000_0000, 64'h0);
        send("lock.rule10", 64'h6000_0004, 4'd10, 1'b0);
        chk("lock.sticky", 64'(cfg_locked_o), 64'd1);

        // Counter saturation after 0xFFFF+5 UART hits
        @(negedge clk_i);
        cfg_cnt_clr_i = 1'b1;
        @(negedge clk_i);
        cfg_cnt_clr_i = 1'b0;
        cnt_of("clr.cnt5", 4'd5, 16'd0);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000_0020;
        repeat (65540) @(negedge clk_i);
        req_valid_i = 1'b0;
        cnt_of("sat.cnt5", 4'd5, 16'hFFFF);
        cnt_of("sat.cnt0", 4'd0, 16'd0);
        @(negedge clk_i);
        req_valid_i   = 1'b1;
        cfg_cnt_clr_i = 1'b1;
        @(negedge clk_i);
        req_valid_i   = 1'b0;
        cfg_cnt_clr_i = 1'b0;
        cnt_of("clrhit.cnt5", 4'd5, 16'd0);
        send("post_clr", 64'h1000_0020, 4'd5, 1'b0);
        cnt_of("post_clr.cnt5", 4'd5, 16'd1);

        // Async reset with a pending result
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000_0040;
        dec_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("mid.pending", 64'(dec_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid.valid", 64'(dec_valid_o), 64'd0);
        chk("mid.idx", 64'(dec_idx_o), 64'd0);
        chk("mid.locked", 64'(cfg_locked_o), 64'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        dec_ready_i = 1'b1;
        cnt_of("mid.cnt5", 4'd5, 16'd0);
        send("mid.rule10", 64'h6000_0004, 4'd11, 1'b1);
        send("mid.rule2", 64'hFFFF_FFFF_FFFF_FFFF, 4'd11, 1'b1);
        send("mid.rule1", 64'h0000_1000, 4'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_addr_decoder.md
Name: soc_addr_decoder

Overview:
- Parametrised, runtime-reprogrammable address decoder for the SoC crossbar.
- Successor to the fixed, compile-time peripheral map.
- Maps a request address to a slave index through a table of NumRules base/length rules, with a registered valid/ready output stage.
- Provides a default/decode-error route, a sticky configuration lock, and per-rule saturating hit counters for debug.

Parameters:
- AddrWidth, 64, address width in bits.
- NumRules, 11, number of decode rules (peripheral count).
- IdxWidth, $clog2(NumRules+1), width of the slave index.
- CntWidth, 16, width of each per-rule hit counter.
- DefaultIdx, NumRules, index returned on a miss (error slave).
- ResetBase, package array, per-rule reset base addresses.
- ResetLength, package array, per-rule reset lengths.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  AddrWidth  request address
- dec_valid_o  out  1  decode result valid
- dec_ready_i  in  1  downstream ready
- dec_idx_o  out  IdxWidth  selected slave index
- dec_err_o  out  1  no rule matched
- dec_addr_o  out  AddrWidth  forwarded address
- cfg_we_i  in  1  rule write strobe
- cfg_idx_i  in  IdxWidth  rule index for write or read
- cfg_base_i  in  AddrWidth  new base
- cfg_len_i  in  AddrWidth  new length (0 = rule disabled)
- cfg_lock_i  in  1  set lock (sticky)
- cfg_locked_o  out  1  lock state
- cfg_cnt_clr_i  in  1  clear all hit counters
- cfg_cnt_o  out  CntWidth  hit counter of rule cfg_idx_i (combinational read)

Behaviour:
- Reset (async, rst_ni low):
  - Table loads ResetBase/ResetLength.
  - dec_valid_o=0, dec_idx_o=0, dec_err_o=0, dec_addr_o=0.
  - cfg_locked_o=0, all counters 0.
- Match rule i: len_i != 0 AND addr >= base_i AND (addr - base_i) < len_i. All arithmetic is unsigned AddrWidth. This form is wrap-safe: a rule ending at 2^AddrWidth never overflows.
- Overlap: the lowest matching index wins.
- Miss: dec_idx_o = DefaultIdx, dec_err_o = 1.
- Output stage: single register with 1-cycle latency.
  - req_ready_o = !dec_valid_o || dec_ready_i. This allows full throughput of one per cycle.
  - Handshake when req_valid_i && req_ready_o: register updates the next cycle.
  - dec_valid_o held with stable idx/err/addr until dec_ready_i.
  - dec_valid_o drops when dec_ready_i is high with no new request.
- Decode uses the table as it stands in the acceptance cycle. A cfg write in the same cycle takes effect for the next request only.
- Config write:
  - Applies when cfg_we_i && !cfg_locked_o && cfg_idx_i < NumRules.
  - Otherwise it is ignored silently: no state change.
- Lock: cfg_lock_i sets cfg_locked_o on the next edge. It clears only on reset.
- Hit counters:
  - Incremented on each accepted request that matches the rule.
  - Saturate at all-ones; no increment on a miss.
  - cfg_cnt_clr_i zeroes all counters. It has priority over a same-cycle increment.
  - cfg_cnt_o returns 0 for cfg_idx_i >= NumRules.
- Reset mid-transfer: pending output is discarded, with dec_valid_o=0 immediately (async).

Decomposition:
- Shared package soc_addr_map_pkg holds:
  - the rule typedef (struct: base, len);
  - NB_PERIPHERALS;
  - the default ResetBase/ResetLength arrays derived from the existing peripheral base/length constants.
- One natural sub-module: soc_addr_rule_match (combinational single-rule comparator). Instantiate NumRules copies, followed by a priority encoder in the top.

Test Plan:
- Reset table: addr 0x1000_0010 -> idx 5 (UART), err 0, one cycle after handshake. Addr 0x8000_0000 -> idx 0 (DRAM).
- Miss: addr 0x6000_0000 -> idx DefaultIdx=11, err 1, no counter increments.
- Backpressure: hold dec_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, output stable. Then dec_ready_i=1 -> back-to-back results, one per cycle.
- Reprogram and lock:
  - Write rule 10 base 0x6000_0000 len 0x1000 -> addr 0x6000_0004 yields idx 10.
  - Assert cfg_lock_i, then write rule 10 len 0 -> ignored, still idx 10.
- Overlap and wrap:
  - Rule 2 set to base 0xFFFF_FFFF_FFFF_F000 len 0x1000 -> addr 0xFFFF_FFFF_FFFF_FFFF hits idx 2.
  - Make rule 1 overlap rule 3 -> idx 1 wins.
- Counters: 0xFFFF+5 UART hits -> cfg_cnt_o=0xFFFF (saturated). cfg_cnt_clr_i with a same-cycle hit -> 0.
